// File: rtl/pe_add.sv
// rtl/pe_add.sv - two-stream lane-wise vector adder with elastic input FIFOs (optional macro PE_ADD_SAT_EN: saturating lanes)

module pe_add_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;

    // A write to a full FIFO is dropped unless the same edge pops a slot free.
    assign push    = wr_en && ((count != CNT_FULL) || rd_en);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Occupancy after the coming edge; also feeds the registered backpressure.
    always_comb begin
        count_next = count;
        if (push && !rd_en) begin
            count_next = count + CNT_ONE;
        end else if (!push && rd_en) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage array; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end
endmodule

module pe_add #(
    parameter int LANES      = 8,
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int BP_MARGIN  = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [LANES-1:0][WIDTH-1:0]   D1,
    input  logic                          D1_VALID,
    output logic                          D1_BP,
    input  logic [LANES-1:0][WIDTH-1:0]   D2,
    input  logic                          D2_VALID,
    output logic                          D2_BP,
    output logic [LANES-1:0][WIDTH-1:0]   Q,
    output logic                          Q_VALID,
    input  logic                          Q_BP
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BP_LEVEL = CW'(FIFO_DEPTH - BP_MARGIN);

    logic [LANES-1:0][WIDTH-1:0] head1;
    logic [LANES-1:0][WIDTH-1:0] head2;
    logic [LANES-1:0][WIDTH-1:0] sum;
    logic                        empty1;
    logic                        empty2;
    logic [CW-1:0]               cnt1_next;
    logic [CW-1:0]               cnt2_next;
    logic                        pop;

    // Join: both heads leave together only when the consumer is not stalling.
    assign pop = !empty1 && !empty2 && !Q_BP;

    pe_add_fifo #(.DW(LANES*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk        (CLK),
        .rst_n      (RST),
        .wr_en      (D1_VALID),
        .wr_data    (D1),
        .rd_en      (pop),
        .rd_data    (head1),
        .empty      (empty1),
        .count_next (cnt1_next)
    );

    pe_add_fifo #(.DW(LANES*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk        (CLK),
        .rst_n      (RST),
        .wr_en      (D2_VALID),
        .wr_data    (D2),
        .rd_en      (pop),
        .rd_data    (head2),
        .empty      (empty2),
        .count_next (cnt2_next)
    );

    // Independent per-lane adders; carries never cross lanes.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef PE_ADD_SAT_EN
        logic [WIDTH:0] wide;
        assign wide   = {1'b0, head1[i]} + {1'b0, head2[i]};
        assign sum[i] = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
`else
        assign sum[i] = head1[i] + head2[i];
`endif
    end

    // Result register: loads on a pop, otherwise holds the last sum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
        end else begin
            Q_VALID <= pop;
            if (pop) begin
                Q <= sum;
            end
        end
    end

    // Advisory backpressure reflecting occupancy after this edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            D1_BP <= 1'b0;
            D2_BP <= 1'b0;
        end else begin
            D1_BP <= (cnt1_next >= BP_LEVEL);
            D2_BP <= (cnt2_next >= BP_LEVEL);
        end
    end
endmodule

// File: tb/tb_pe_add.sv
// tb/tb_pe_add.sv - self-checking bench for pe_add (directed table, sequences and randomized model compare)

module tb_pe_add;
    localparam int LANES = 8;
    localparam int WIDTH = 64;
    localparam int DEPTH = 8;
    localparam int BP_AT = 5;
`ifdef PE_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
    typedef struct {
        vec_t a;
        vec_t b;
        vec_t q;
    } vec_rec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    vec_t D1 = '0;
    vec_t D2 = '0;
    logic D1_VALID = 1'b0;
    logic D2_VALID = 1'b0;
    logic D1_BP;
    logic D2_BP;
    vec_t Q;
    logic Q_VALID;
    logic Q_BP = 1'b0;

    int checks = 0;
    int errors = 0;

    vec_t mq1[$];
    vec_t mq2[$];
    vec_t exp_q  = '0;
    logic exp_qv = 1'b0;
    logic exp_bp1 = 1'b0;
    logic exp_bp2 = 1'b0;
    vec_t z = '0;

    pe_add dut (
        .CLK      (CLK),
        .RST      (RST),
        .D1       (D1),
        .D1_VALID (D1_VALID),
        .D1_BP    (D1_BP),
        .D2       (D2),
        .D2_VALID (D2_VALID),
        .D2_BP    (D2_BP),
        .Q        (Q),
        .Q_VALID  (Q_VALID),
        .Q_BP     (Q_BP)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic chk64(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chkv(input string name, input vec_t got, input vec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic vec_t ref_add(input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < LANES; i++) begin
            logic [WIDTH:0] wide;
            wide = {1'b0, a[i]} + {1'b0, b[i]};
            r[i] = (SAT && wide[WIDTH]) ? MAX : wide[WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i] = MAX;
                1:       v[i] = 64'($urandom_range(0, 1000));
                default: v[i] = {$urandom, $urandom};
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        mq1.delete();
        mq2.delete();
        exp_q   = '0;
        exp_qv  = 1'b0;
        exp_bp1 = 1'b0;
        exp_bp2 = 1'b0;
    endtask

    // Queue-level reference: pair oldest entries, then accept new beats if room.
    task automatic model_edge(input logic v1, input vec_t a, input logic v2, input vec_t b, input logic bp);
        if (mq1.size() > 0 && mq2.size() > 0 && !bp) begin
            exp_q  = ref_add(mq1.pop_front(), mq2.pop_front());
            exp_qv = 1'b1;
        end else begin
            exp_qv = 1'b0;
        end
        if (v1 && mq1.size() < DEPTH) mq1.push_back(a);
        if (v2 && mq2.size() < DEPTH) mq2.push_back(b);
        exp_bp1 = (mq1.size() >= BP_AT);
        exp_bp2 = (mq2.size() >= BP_AT);
    endtask

    task automatic check_outputs();
        chk1("q_valid", Q_VALID, exp_qv);
        chkv("q", Q, exp_q);
        chk1("d1_bp", D1_BP, exp_bp1);
        chk1("d2_bp", D2_BP, exp_bp2);
    endtask

    task automatic cycle(input logic v1, input vec_t a, input logic v2, input vec_t b, input logic bp);
        D1_VALID = v1;
        D1       = a;
        D2_VALID = v2;
        D2       = b;
        Q_BP     = bp;
        @(posedge CLK);
        model_edge(v1, a, v2, b, bp);
        #1;
        check_outputs();
    endtask

    vec_rec_t tbl [4];

    initial begin
        vec_t a;
        vec_t b;

        for (int r = 0; r < 4; r++) begin
            tbl[r].a = '0;
            tbl[r].b = '0;
            tbl[r].q = '0;
        end
        tbl[0].a[3] = MAX;     tbl[0].b[3] = 64'd1;
        tbl[0].a[4] = 64'd5;   tbl[0].b[4] = 64'd7;
        tbl[0].q[3] = SAT ? MAX : 64'd0;
        tbl[0].q[4] = 64'd12;
        for (int i = 0; i < LANES; i++) begin
            tbl[1].a[i] = MAX;
            tbl[1].b[i] = MAX;
            tbl[1].q[i] = SAT ? MAX : 64'hFFFF_FFFF_FFFF_FFFE;
            tbl[2].a[i] = 64'(i) * 64'd1000;
            tbl[2].b[i] = 64'h8000_0000_0000_0000;
            tbl[2].q[i] = 64'h8000_0000_0000_0000 + 64'(i) * 64'd1000;
            tbl[3].a[i] = 64'h8000_0000_0000_0000;
            tbl[3].b[i] = 64'h8000_0000_0000_0000 | 64'(i);
            tbl[3].q[i] = SAT ? MAX : 64'(i);
        end

        // Reset held for 12 cycles
        model_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK);
            #1;
            check_outputs();
        end
        RST = 1'b1;
        for (int c = 0; c < 3; c++) cycle(0, z, 0, z, 0);

        // Back-to-back stream
        for (int k = 0; k < 6; k++) begin
            a = '0;
            b = '0;
            a[0] = 64'd1111;
            b[0] = 64'd1111 * 64'(k + 1);
            if (k < 4) cycle(1, a, 1, b, 0);
            else       cycle(0, z, 0, z, 0);
            if (k == 0 || k == 5) begin
                chk1("b2b_valid_off", Q_VALID, 1'b0);
            end else begin
                chk1("b2b_valid_on", Q_VALID, 1'b1);
                chk64("b2b_q0", Q[0], 64'd1111 * 64'(k + 1));
                chk64("b2b_q1", Q[1], 64'd0);
            end
        end

        // Table-driven lane / wrap vectors
        for (int r = 0; r < 4; r++) begin
            cycle(1, tbl[r].a, 1, tbl[r].b, 0);
            cycle(0, z, 0, z, 0);
            chk1("tbl_valid", Q_VALID, 1'b1);
            chkv("tbl_q", Q, tbl[r].q);
        end
        cycle(0, z, 0, z, 0);

        // Stall: Q_BP rises with the data and holds six cycles
        a = '0;
        a[0] = 64'd150;
        cycle(1, a, 1, a, 1);
        chk1("stall_hold", Q_VALID, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle(0, z, 0, z, 1);
            chk1("stall_hold", Q_VALID, 1'b0);
        end
        cycle(0, z, 0, z, 0);
        chk1("stall_release", Q_VALID, 1'b1);
        chk64("stall_q0", Q[0], 64'd300);
        cycle(0, z, 0, z, 0);
        chk1("stall_once", Q_VALID, 1'b0);

        // Backpressure and overflow
        for (int k = 1; k <= 10; k++) begin
            a = '0;
            b = '0;
            a[0] = 64'(k);
            b[0] = 64'(100 + k);
            cycle(1, a, 1, b, 1);
            chk1("bp_d1", D1_BP, k >= BP_AT);
            chk1("bp_d2", D2_BP, k >= BP_AT);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(0, z, 0, z, 0);
            chk1("drain_valid", Q_VALID, 1'b1);
            chk64("drain_q0", Q[0], 64'(2 * k + 100));
        end
        cycle(0, z, 0, z, 0);
        chk1("drain_done", Q_VALID, 1'b0);

        // Join skew: D1 leads D2 by three cycles
        for (int k = 0; k < 7; k++) begin
            a = '0;
            b = '0;
            a[0] = 64'(10 + k);
            b[0] = 64'(20 + k - 3);
            cycle(k < 3, a, (k >= 3 && k < 6), b, 0);
            if (k < 4) begin
                chk1("skew_wait", Q_VALID, 1'b0);
            end else begin
                chk1("skew_valid", Q_VALID, 1'b1);
                chk64("skew_q0", Q[0], 64'(30 + 2 * (k - 4)));
            end
        end
        cycle(0, z, 0, z, 0);

        // Reset mid-drain
        for (int k = 0; k < 6; k++) cycle(1, rnd_vec(), 1, rnd_vec(), 1);
        cycle(0, z, 0, z, 0);
        chk1("pre_rst_valid", Q_VALID, 1'b1);
        chk1("pre_rst_bp", D1_BP, 1'b1);
        #1;
        RST = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        check_outputs();
        RST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(0, z, 0, z, 0);
            chk1("post_rst_empty", Q_VALID, 1'b0);
        end
        cycle(1, tbl[0].a, 0, z, 0);
        cycle(0, z, 1, tbl[0].b, 0);
        cycle(0, z, 0, z, 0);
        chkv("post_rst_pair", Q, tbl[0].q);

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 9) < 7, rnd_vec(),
                  $urandom_range(0, 9) < 6, rnd_vec(),
                  $urandom_range(0, 3) == 0);
        end
        for (int c = 0; c < 12; c++) cycle(0, z, 0, z, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
